// File: rtl/ff_bist_checker.sv
// On-chip self-test for a single reset flop: LFSR stream out on d_out, q_in compared two edges later.
// Optional first-mismatch index output enabled by defining BIST_FIRST_ERR_EN.
module ff_bist_checker #(
    parameter int          N_BITS = 16,
    parameter int          ERR_W  = 8,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             d_out,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef BIST_FIRST_ERR_EN
    ,
    output logic [7:0]       first_err_idx
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_IDX = 8'(N_BITS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_lfsr;
    logic [7:0]         r_bit_idx;
    logic               r_drain_cnt;
    logic               r_d_out;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err;
    logic               r_exp1;
    logic               r_vld1;
    logic               r_exp2;
    logic               r_vld2;

    logic               w_fb;
    logic [7:0]         w_lfsr_shift;
    logic               w_accept;
    logic               w_last_bit;
    logic               w_mismatch;
    logic               w_err_sat;

    assign w_fb         = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_lfsr_shift = {r_lfsr[6:0], w_fb};
    // DONE exits on the same edge IDLE would sample start, so a held start restarts back-to-back.
    assign w_accept     = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_last_bit   = (r_bit_idx == LAST_IDX);
    assign w_mismatch   = r_vld2 & (q_in != r_exp2);
    assign w_err_sat    = &r_err;

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
                else       w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (w_last_bit) w_state_nxt = ST_DRAIN;
                else            w_state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                if (r_drain_cnt) w_state_nxt = ST_DONE;
                else             w_state_nxt = ST_DRAIN;
            end
            ST_DONE: begin
                if (start) w_state_nxt = ST_RUN;
                else       w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, stimulus generator and stage-1 of the expected-bit pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= SEED_EFF;
            r_bit_idx   <= 8'd0;
            r_drain_cnt <= 1'b0;
            r_d_out     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_exp1      <= 1'b0;
            r_vld1      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_lfsr    <= SEED_EFF;
                r_bit_idx <= 8'd0;
                r_d_out   <= SEED_EFF[7];
                r_exp1    <= SEED_EFF[7];
                r_vld1    <= 1'b1;
            end else if (r_state == ST_RUN) begin
                if (w_last_bit) begin
                    r_d_out     <= 1'b0;
                    r_vld1      <= 1'b0;
                    r_drain_cnt <= 1'b0;
                end else begin
                    r_lfsr    <= w_lfsr_shift;
                    r_bit_idx <= r_bit_idx + 8'd1;
                    r_d_out   <= w_lfsr_shift[7];
                    r_exp1    <= w_lfsr_shift[7];
                    r_vld1    <= 1'b1;
                end
            end else begin
                r_vld1      <= 1'b0;
                r_drain_cnt <= (r_state == ST_DRAIN);
            end
        end
    end

    // Stage-2 of the pipeline, saturating mismatch counter and verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp2 <= 1'b0;
            r_vld2 <= 1'b0;
            r_err  <= {ERR_W{1'b0}};
            r_pass <= 1'b0;
        end else if (w_accept) begin
            r_exp2 <= 1'b0;
            r_vld2 <= 1'b0;
            r_err  <= {ERR_W{1'b0}};
            r_pass <= 1'b0;
        end else begin
            r_exp2 <= r_exp1;
            r_vld2 <= r_vld1;
            if (w_mismatch && !w_err_sat) r_err <= r_err + ERR_W'(1);
            if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DONE)) r_pass <= (r_err == {ERR_W{1'b0}});
        end
    end

`ifdef BIST_FIRST_ERR_EN
    logic [7:0] r_cmp_idx;
    logic [7:0] r_first_err;

    // Index of the compared bit tracks valid compares; 8'hFF means no mismatch seen yet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmp_idx   <= 8'd0;
            r_first_err <= 8'hFF;
        end else if (w_accept) begin
            r_cmp_idx   <= 8'd0;
            r_first_err <= 8'hFF;
        end else if (r_vld2) begin
            r_cmp_idx <= r_cmp_idx + 8'd1;
            if (w_mismatch && (r_first_err == 8'hFF)) r_first_err <= r_cmp_idx;
        end
    end

    assign first_err_idx = r_first_err;
`endif

    assign d_out     = r_d_out;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;

endmodule

// File: tb/tb_ff_bist_checker.sv
// Randomized self-checking bench for ff_bist_checker with a behavioural flop-under-test and error injection.
module tb_ff_bist_checker;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       d_out, busy, done, pass;
    logic [7:0] err_count;
    logic       q_in;
    logic       d_out_s, busy_s, done_s, pass_s;
    logic [2:0] err_count_s;
    logic       q_in_s;
`ifdef BIST_FIRST_ERR_EN
    logic [7:0] first_err_idx, first_err_idx_s;
`endif

    logic       inj;
    int         mode;
    logic       ff_q, ff_q_s;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [15:0] ref_stream = 16'b1010_0101_0100_1110;

    always #5 clk = ~clk;

    // Flop under test, with a bit-flip injected on its d path when inj is high.
    always @(posedge clk or posedge reset) begin
        if (reset) ff_q <= 1'b0;
        else       ff_q <= d_out ^ inj;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) ff_q_s <= 1'b0;
        else       ff_q_s <= d_out_s;
    end

    always_comb begin
        case (mode)
            1:       q_in = 1'b0;
            2:       q_in = 1'b1;
            3:       q_in = ~ff_q;
            default: q_in = ff_q;
        endcase
    end
    assign q_in_s = ~ff_q_s;

    ff_bist_checker u_dut (
        .clk(clk), .reset(reset), .start(start), .d_out(d_out), .q_in(q_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef BIST_FIRST_ERR_EN
        , .first_err_idx(first_err_idx)
`endif
    );

    ff_bist_checker #(.ERR_W(3)) u_sat (
        .clk(clk), .reset(reset), .start(start), .d_out(d_out_s), .q_in(q_in_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s)
`ifdef BIST_FIRST_ERR_EN
        , .first_err_idx(first_err_idx_s)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_bit(input int k);
        return ref_stream[15-k];
    endfunction

    // One run; m selects the q_in path, mask flips individual transmitted bits in the flop.
    task automatic run_once(input int m, input logic [N-1:0] mask);
        int   errs;
        int   first;
        int   cyc;
        logic recv;
        errs  = 0;
        first = 255;
        for (int k = 0; k < N; k++) begin
            case (m)
                1:       recv = 1'b0;
                2:       recv = 1'b1;
                3:       recv = ~(ref_bit(k) ^ mask[k]);
                default: recv = ref_bit(k) ^ mask[k];
            endcase
            if (recv != ref_bit(k)) begin
                errs++;
                if (first == 255) first = k;
            end
        end
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        inj   = mask[0];
        check_eq("busy_e0", {31'd0, busy}, 32'd1);
        check_eq("dout_bit0", {31'd0, d_out}, {31'd0, ref_bit(0)});
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            inj = (cyc < N) ? mask[cyc] : 1'b0;
            if (done) break;
            if (cyc < N) check_eq("dout_bit", {31'd0, d_out}, {31'd0, ref_bit(cyc)});
            if (cyc == N) check_eq("dout_zero_drain", {31'd0, d_out}, 32'd0);
            check_eq("busy_run", {31'd0, busy}, 32'd1);
        end
        check_eq("done_cycle", cyc, N + 2);
        check_eq("busy_done", {31'd0, busy}, 32'd0);
        check_eq("err_count", {24'd0, err_count}, (errs > 255) ? 32'd255 : errs);
        check_eq("pass", {31'd0, pass}, (errs == 0) ? 32'd1 : 32'd0);
        check_eq("err_count_sat", {29'd0, err_count_s}, 32'd7);
`ifdef BIST_FIRST_ERR_EN
        check_eq("first_err_idx", {24'd0, first_err_idx}, first);
`endif
        @(posedge clk);
        #1;
        check_eq("done_pulse_end", {31'd0, done}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("hold_err", {24'd0, err_count}, (errs > 255) ? 32'd255 : errs);
    endtask

    initial begin
        int        done_cycles[$];
        logic [N-1:0] rmask;
        reset = 1'b1;
        start = 1'b0;
        inj   = 1'b0;
        mode  = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_dout", {31'd0, d_out}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_pass", {31'd0, pass}, 32'd0);
        check_eq("rst_err", {24'd0, err_count}, 32'd0);
`ifdef BIST_FIRST_ERR_EN
        check_eq("rst_first", {24'd0, first_err_idx}, 32'hFF);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        run_once(0, 16'h0000);
        run_once(1, 16'h0000);
        run_once(2, 16'h0000);
        run_once(3, 16'h0000);
        for (int r = 0; r < 8; r++) begin
            rmask = N'($urandom);
            if (r % 3 == 0) rmask = rmask & N'($urandom) & N'($urandom);
            run_once(($urandom_range(0, 3) == 0) ? 3 : 0, rmask);
        end

        // Reset pulse mid-run at e5.
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        inj   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_dout", {31'd0, d_out}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        check_eq("mid_rst_pass", {31'd0, pass}, 32'd0);
        check_eq("mid_rst_err", {24'd0, err_count}, 32'd0);
`ifdef BIST_FIRST_ERR_EN
        check_eq("mid_rst_first", {24'd0, first_err_idx}, 32'hFF);
`endif
        @(negedge clk);
        reset = 1'b0;
        inj   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_idle", {30'd0, busy, done}, 32'd0);
        run_once(0, 16'h0000);

        // start held high: one done per accepted start, 19 cycles apart.
        @(negedge clk);
        mode  = 0;
        inj   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 62; c++) begin
            @(posedge clk);
            #1;
            if (c == 40) start = 1'b0;
            if (done) done_cycles.push_back(c);
        end
        check_eq("hold_done_count", done_cycles.size(), 32'd3);
        for (int i = 0; i < done_cycles.size() && i < 3; i++)
            check_eq("hold_done_cycle", done_cycles[i], 18 + 19 * i);
        check_eq("hold_pass", {31'd0, pass}, 32'd1);
        check_eq("hold_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
